// File: rtl/mem_pkg.sv
// Shared definitions for the memory self-test initiator and its RAM partner:
// FSM state encoding, command mode codes and the default geometry.
package mem_pkg;

  localparam int MEM_W      = 8;
  localparam int MEM_ADDR_W = 4;
  localparam int MEM_D      = 1 << MEM_ADDR_W;

  localparam logic [1:0] MODE_WR   = 2'd0;
  localparam logic [1:0] MODE_RD   = 2'd1;
  localparam logic [1:0] MODE_WRRD = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FIN
  } mem_init_state_t;

endpackage

// File: rtl/mem_req_watchdog.sv
// Response watchdog: counts stalled wait cycles and flags expiry on the
// cycle the count would reach TIMEOUT.
module mem_req_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  assign o_expire = i_enable && (r_cnt == LIMIT);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expire) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Memory self-test initiator: writes a seeded incrementing pattern over a
// wrapping address range and/or reads it back, counting mismatches.
module mem_initiator
  import mem_pkg::*;
#(
  parameter int W       = MEM_W,
  parameter int D       = MEM_D,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [W-1:0]      seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              timeout_err,
  output logic              valid,
  output logic              wrd,
  output logic [ADDR_W-1:0] addr,
  output logic [W-1:0]      wdata,
  input  logic              ready,
  input  logic [W-1:0]      rdata
);

  localparam logic [ADDR_W:0] K_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(D);

  mem_init_state_t   r_state;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [W-1:0]      r_seed;
  logic [ADDR_W:0]   r_k;

  logic              r_busy;
  logic              r_done;
  logic [ADDR_W:0]   r_err_cnt;
  logic              r_first_err_valid;
  logic [ADDR_W-1:0] r_first_err_addr;
  logic              r_timeout_err;
  logic              r_valid;
  logic              r_wrd;
  logic [ADDR_W-1:0] r_addr;
  logic [W-1:0]      r_wdata;

  logic [ADDR_W:0]   w_k_next;
  logic [ADDR_W-1:0] w_addr_k;
  logic [ADDR_W-1:0] w_addr_next;
  logic [W-1:0]      w_data_k;
  logic [W-1:0]      w_data_next;
  logic              w_last;
  logic              w_mismatch;
  logic              w_wd_clear;
  logic              w_wd_enable;
  logic              w_wd_expire;

  // Address and data wrap naturally by truncation to their widths.
  assign w_k_next    = r_k + K_ONE;
  assign w_addr_k    = r_base + r_k[ADDR_W-1:0];
  assign w_addr_next = r_base + w_k_next[ADDR_W-1:0];
  assign w_data_k    = r_seed + W'(r_k);
  assign w_data_next = r_seed + W'(w_k_next);
  assign w_last      = (w_k_next == r_len);
  assign w_mismatch  = (rdata != w_data_k);

  assign w_wd_clear  = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
  assign w_wd_enable = ((r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT)) && !ready;

  mem_req_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= ST_IDLE;
      r_mode            <= MODE_WR;
      r_base            <= '0;
      r_len             <= '0;
      r_seed            <= '0;
      r_k               <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_err_cnt         <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_addr  <= '0;
      r_timeout_err     <= 1'b0;
      r_valid           <= 1'b0;
      r_wrd             <= 1'b0;
      r_addr            <= '0;
      r_wdata           <= '0;
    end else begin
      // Request strobe and completion flag are single-cycle pulses.
      r_valid <= 1'b0;
      r_done  <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode            <= mode;
            r_base            <= base_addr;
            r_len             <= (len > LEN_MAX) ? LEN_MAX : len;
            r_seed            <= seed;
            r_k               <= '0;
            r_busy            <= 1'b1;
            r_err_cnt         <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_addr  <= '0;
            r_timeout_err     <= 1'b0;
            if ((len == '0) || (mode == MODE_RSVD)) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else if (mode == MODE_RD) begin
              r_state <= ST_RD_REQ;
              r_valid <= 1'b1;
              r_wrd   <= 1'b0;
              r_addr  <= base_addr;
              r_wdata <= '0;
            end else begin
              r_state <= ST_WR_REQ;
              r_valid <= 1'b1;
              r_wrd   <= 1'b1;
              r_addr  <= base_addr;
              r_wdata <= seed;
            end
          end
        end

        ST_WR_REQ: r_state <= ST_WR_WAIT;
        ST_RD_REQ: r_state <= ST_RD_WAIT;

        ST_WR_WAIT: begin
          if (ready) begin
            if (w_last && (r_mode == MODE_WRRD)) begin
              r_k     <= '0;
              r_state <= ST_RD_REQ;
              r_valid <= 1'b1;
              r_wrd   <= 1'b0;
              r_addr  <= r_base;
              r_wdata <= '0;
            end else if (w_last) begin
              r_k     <= w_k_next;
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_k     <= w_k_next;
              r_state <= ST_WR_REQ;
              r_valid <= 1'b1;
              r_wrd   <= 1'b1;
              r_addr  <= w_addr_next;
              r_wdata <= w_data_next;
            end
          end else if (w_wd_expire) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_FIN;
            r_done        <= 1'b1;
          end
        end

        ST_RD_WAIT: begin
          if (ready) begin
            if (w_mismatch) begin
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + K_ONE;
              if (!r_first_err_valid) begin
                r_first_err_valid <= 1'b1;
                r_first_err_addr  <= w_addr_k;
              end
            end
            r_k <= w_k_next;
            if (w_last) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RD_REQ;
              r_valid <= 1'b1;
              r_wrd   <= 1'b0;
              r_addr  <= w_addr_next;
              r_wdata <= '0;
            end
          end else if (w_wd_expire) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_FIN;
            r_done        <= 1'b1;
          end
        end

        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign err_cnt         = r_err_cnt;
  assign first_err_valid = r_first_err_valid;
  assign first_err_addr  = r_first_err_addr;
  assign timeout_err     = r_timeout_err;
  assign valid           = r_valid;
  assign wrd             = r_wrd;
  assign addr            = r_addr;
  assign wdata           = r_wdata;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a behavioural single-port RAM that
// answers one cycle after each request, plus a stall control to force timeouts.
module tb_mem_initiator;
  import mem_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [3:0] base_addr;
  logic [4:0] len;
  logic [7:0] seed;
  logic       busy;
  logic       done;
  logic [4:0] err_cnt;
  logic       first_err_valid;
  logic [3:0] first_err_addr;
  logic       timeout_err;
  logic       valid;
  logic       wrd;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic [7:0] rdata;

  logic [7:0] mem [0:15];
  logic       ram_stall;
  int         n_valid;
  int         n_tests;
  int         n_fail;

  mem_initiator #(
    .W       (8),
    .D       (16),
    .ADDR_W  (4),
    .TIMEOUT (15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .mode            (mode),
    .base_addr       (base_addr),
    .len             (len),
    .seed            (seed),
    .busy            (busy),
    .done            (done),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_addr  (first_err_addr),
    .timeout_err     (timeout_err),
    .valid           (valid),
    .wrd             (wrd),
    .addr            (addr),
    .wdata           (wdata),
    .ready           (ready),
    .rdata           (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NOTE: the RAM array has no reset, matching real SRAM; only its handshake
  // flops are cleared.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid && !ram_stall;
      if (valid && !ram_stall) begin
        if (wrd) mem[addr] <= wdata;
        rdata <= mem[addr];
      end
    end
  end

  always @(posedge clk) if (valid) n_valid++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command and measures on which edge after the start edge the
  // FSM entered FIN. Optionally pulses start mid-command and during FIN.
  task automatic run_cmd(input logic [1:0] m, input logic [3:0] b, input logic [4:0] l,
                         input logic [7:0] s, input int exp_edges, input string tag,
                         input int poke_at, input bit poke_fin);
    int cyc;
    bit seen;
    @(negedge clk);
    mode = m; base_addr = b; len = l; seed = s; start = 1'b1;
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_at != 0 && cyc == poke_at) begin
        start = 1'b1; mode = MODE_RSVD; len = '0;
      end
      if (done) seen = 1'b1;
      else cyc++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_done_edge"}, 32'(cyc), 32'(exp_edges));
    check({tag, "_busy_in_fin"}, 32'(busy), 32'd1);
    if (poke_fin) begin
      start = 1'b1; mode = MODE_RSVD; len = '0;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int v0;
    n_tests = 0; n_fail = 0; n_valid = 0;
    rst = 1'b0; start = 1'b0; mode = '0; base_addr = '0; len = '0; seed = '0;
    ram_stall = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    rst = 1'b1;

    // Full write-fill: 2 cycles per word.
    run_cmd(MODE_WR, 4'd0, 5'd16, 8'h10, 32, "fill", 0, 1'b0);
    for (int i = 0; i < 16; i++) check($sformatf("fill_mem%0d", i), 32'(mem[i]), 32'(8'h10 + i));
    check("fill_err_cnt", 32'(err_cnt), 32'd0);

    // Write then read across the address wrap and the data wrap.
    v0 = n_valid;
    run_cmd(MODE_WRRD, 4'd14, 5'd4, 8'hFE, 16, "wrap", 0, 1'b0);
    check("wrap_mem14", 32'(mem[14]), 32'hFE);
    check("wrap_mem15", 32'(mem[15]), 32'hFF);
    check("wrap_mem0", 32'(mem[0]), 32'h00);
    check("wrap_mem1", 32'(mem[1]), 32'h01);
    check("wrap_err_cnt", 32'(err_cnt), 32'd0);
    check("wrap_first_vld", 32'(first_err_valid), 32'd0);
    check("wrap_valid_pulses", 32'(n_valid - v0), 32'd8);

    // Preload 4:04, 5:AA, 6:06, then read-check expecting 04,05,06.
    run_cmd(MODE_WR, 4'd4, 5'd3, 8'h04, 6, "pre_a", 0, 1'b0);
    run_cmd(MODE_WR, 4'd5, 5'd1, 8'hAA, 2, "pre_b", 0, 1'b0);
    run_cmd(MODE_RD, 4'd4, 5'd3, 8'h04, 6, "mism", 0, 1'b0);
    check("mism_err_cnt", 32'(err_cnt), 32'd1);
    check("mism_first_vld", 32'(first_err_valid), 32'd1);
    check("mism_first_addr", 32'(first_err_addr), 32'd5);

    // Full wrapped read from 2: mismatches at 4,5,6,14,15,0,1; first is 4.
    run_cmd(MODE_RD, 4'd2, 5'd16, 8'h12, 32, "multi", 0, 1'b0);
    check("multi_err_cnt", 32'(err_cnt), 32'd7);
    check("multi_first_addr", 32'(first_err_addr), 32'd4);

    // RAM never answers: one request, 15 stalled wait cycles, then abort.
    ram_stall = 1'b1;
    v0 = n_valid;
    run_cmd(MODE_WR, 4'd0, 5'd4, 8'h55, 16, "tmo", 0, 1'b0);
    check("tmo_flag", 32'(timeout_err), 32'd1);
    check("tmo_valid_pulses", 32'(n_valid - v0), 32'd1);
    check("tmo_err_cnt", 32'(err_cnt), 32'd0);
    ram_stall = 1'b0;

    // Degenerate commands finish on the start edge with no bus traffic.
    v0 = n_valid;
    run_cmd(MODE_WR, 4'd3, 5'd0, 8'h00, 0, "len0", 0, 1'b0);
    check("len0_tmo_cleared", 32'(timeout_err), 32'd0);
    run_cmd(MODE_RSVD, 4'd3, 5'd5, 8'h00, 0, "rsvd", 0, 1'b0);
    check("degen_valid_pulses", 32'(n_valid - v0), 32'd0);

    // start mid-command and during FIN must both be ignored.
    run_cmd(MODE_RD, 4'd4, 5'd3, 8'h04, 6, "busy", 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("busy_no_redo%0d", i), 32'({busy, done}), 32'd0);
    end
    check("busy_hold_err_cnt", 32'(err_cnt), 32'd1);
    check("busy_hold_first_addr", 32'(first_err_addr), 32'd5);

    // Reset during RD_WAIT abandons the command immediately.
    @(negedge clk);
    mode = MODE_RD; base_addr = 4'd9; len = 5'd4; seed = 8'h19; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("rmid_req_valid", 32'(valid), 32'd1);
    @(negedge clk);
    check("rmid_wait_busy", 32'(busy), 32'd1);
    check("rmid_wait_addr", 32'(addr), 32'd9);
    rst = 1'b0;
    #1;
    check("rmid_valid", 32'(valid), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_done", 32'(done), 32'd0);
    check("rmid_addr", 32'(addr), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rmid_no_done", 32'(done), 32'd0);
    end
    rst = 1'b1;

    run_cmd(MODE_WRRD, 4'd8, 5'd2, 8'h38, 8, "post_rst", 0, 1'b0);
    check("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("post_rst_mem8", 32'(mem[8]), 32'h38);
    check("post_rst_mem9", 32'(mem[9]), 32'h39);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
